program_store: RTL and testbench



---
 rtl/program_store_pkg.sv | 19 +
 rtl/program_store_byte_assembler.sv | 59 +++++
 rtl/program_store.sv | 139 +++++++++++++
 tb/tb_program_store.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/program_store_pkg.sv
// Shared types, constants and helpers for the program_store instruction memory.
package program_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default program: load 10 into r6, then keep emitting r6.
    localparam logic [15:0] OPC_ADDI_R6_10 = 16'h1C0A;
    localparam logic [15:0] OPC_OUT_R6     = 16'hFC00;

    // Number of load-stream bytes that make up one instruction word.
    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/program_store_byte_assembler.sv
// Collects big-endian bytes into one instruction word; flags the word on its last byte.
module program_store_byte_assembler
    import program_store_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_valid
);

    localparam int BPW   = bytes_per_word(DATA_W);
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0] r_idx;
    logic             w_last;

    assign w_last       = (r_idx == IDX_W'(BPW - 1));
    // The word is complete on the same edge its final byte is accepted.
    assign o_word_valid = i_byte_valid && w_last;

    // Byte index within the word being assembled.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_idx <= '0;
        end else if (i_byte_valid) begin
            r_idx <= w_last ? '0 : (r_idx + IDX_W'(1));
        end else begin
            r_idx <= r_idx;
        end
    end

    generate
        if (BPW == 1) begin : g_single
            assign o_word = i_byte;
        end else begin : g_multi
            // Earlier bytes of the word; the first byte ends up in the top lane.
            logic [DATA_W-9:0] r_shift;

            assign o_word = {r_shift, i_byte};

            // Shift each accepted byte in from the bottom.
            always_ff @(posedge i_clk) begin
                if (i_rst || i_clear) begin
                    r_shift <= '0;
                end else if (i_byte_valid) begin
                    r_shift <= o_word[DATA_W-9:0];
                end else begin
                    r_shift <= r_shift;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/program_store.sv
// Field-loadable instruction memory: registered fetch port plus byte-stream reload FSM.
module program_store
    import program_store_pkg::*;
#(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 3,
    parameter string INIT_FILE = ""
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_en,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_inst_valid,
    input  logic              i_load_start,
    input  logic [7:0]        i_load_byte,
    input  logic              i_load_byte_valid,
    output logic              o_load_byte_ready,
    output logic              o_load_busy,
    output logic              o_load_done,
    output logic [ADDR_W:0]   o_load_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_instruction;
    logic              r_inst_valid;

    logic              w_start;
    logic              w_accept;
    logic [DATA_W-1:0] w_word;
    logic              w_word_valid;

    // Power-up image: the built-in default program.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            if (DATA_W == 16) begin
                r_mem[i] = (i == 0) ? DATA_W'(OPC_ADDI_R6_10) : DATA_W'(OPC_OUT_R6);
            end else begin
                r_mem[i] = '0;
            end
        end
    end

    assign w_start  = (r_state == ST_IDLE) && i_load_start;
    // Reset wins over a byte arriving on the same edge, so no half-aborted write.
    assign w_accept = i_load_byte_valid && (r_state == ST_LOAD) && !i_rst;

    program_store_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clear      (w_start),
        .i_byte       (i_load_byte),
        .i_byte_valid (w_accept),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    // Next-state decode for the reload sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_state_next = ST_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_word_valid && (r_ptr == {ADDR_W{1'b1}})) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register, write pointer and reload word counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_ptr   <= '0;
                r_count <= '0;
            end else if (w_word_valid) begin
                r_ptr   <= r_ptr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W + 1)'(1);
            end else begin
                r_ptr   <= r_ptr;
                r_count <= r_count;
            end
        end
    end

    // Memory write port; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (w_word_valid) begin
            r_mem[r_ptr] <= w_word;
        end
    end

    // Registered fetch; blocked while a reload is rewriting the array.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_instruction <= '0;
            r_inst_valid  <= 1'b0;
        end else if (i_fetch_en && (r_state != ST_LOAD)) begin
            r_instruction <= r_mem[i_fetch_addr];
            r_inst_valid  <= 1'b1;
        end else begin
            r_instruction <= r_instruction;
            r_inst_valid  <= 1'b0;
        end
    end

    assign o_instruction     = r_instruction;
    assign o_inst_valid      = r_inst_valid;
    assign o_load_byte_ready = (r_state == ST_LOAD);
    assign o_load_busy       = (r_state == ST_LOAD);
    assign o_load_done       = (r_state == ST_DONE);
    assign o_load_count      = r_count;

endmodule

// File: tb/tb_program_store.sv
// Directed bench for program_store: default image, reloads, aborts and a 32-bit config.
module tb_program_store;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default configuration instance (16-bit words, 8 deep).
    logic        a_rst, a_fetch_en, a_start, a_bv;
    logic [2:0]  a_fetch_addr;
    logic [7:0]  a_byte;
    logic [15:0] a_instr;
    logic        a_iv, a_ready, a_busy, a_done;
    logic [3:0]  a_count;

    // Wide configuration instance (32-bit words, 4 deep).
    logic        b_rst, b_fetch_en, b_start, b_bv;
    logic [1:0]  b_fetch_addr;
    logic [7:0]  b_byte;
    logic [31:0] b_instr;
    logic        b_iv, b_ready, b_busy, b_done;
    logic [2:0]  b_count;

    int n_checks = 0;
    int n_pass   = 0;

    program_store #(.DATA_W(16), .ADDR_W(3)) u_dut (
        .i_clk(clk), .i_rst(a_rst), .i_fetch_en(a_fetch_en), .i_fetch_addr(a_fetch_addr),
        .o_instruction(a_instr), .o_inst_valid(a_iv), .i_load_start(a_start),
        .i_load_byte(a_byte), .i_load_byte_valid(a_bv), .o_load_byte_ready(a_ready),
        .o_load_busy(a_busy), .o_load_done(a_done), .o_load_count(a_count)
    );

    program_store #(.DATA_W(32), .ADDR_W(2)) u_dut_wide (
        .i_clk(clk), .i_rst(b_rst), .i_fetch_en(b_fetch_en), .i_fetch_addr(b_fetch_addr),
        .o_instruction(b_instr), .o_inst_valid(b_iv), .i_load_start(b_start),
        .i_load_byte(b_byte), .i_load_byte_valid(b_bv), .o_load_byte_ready(b_ready),
        .o_load_busy(b_busy), .o_load_done(b_done), .o_load_count(b_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_a(input logic [2:0] addr, input logic [15:0] exp, input string tag);
        a_fetch_en   = 1'b1;
        a_fetch_addr = addr;
        tick();
        check(tag, 64'(a_instr), 64'(exp));
        check({tag, "_v"}, 64'(a_iv), 64'd1);
        a_fetch_en = 1'b0;
    endtask

    task automatic fetch_b(input logic [1:0] addr, input logic [31:0] exp, input string tag);
        b_fetch_en   = 1'b1;
        b_fetch_addr = addr;
        tick();
        check(tag, 64'(b_instr), 64'(exp));
        check({tag, "_v"}, 64'(b_iv), 64'd1);
        b_fetch_en = 1'b0;
    endtask

    initial begin
        int ready_cnt;
        int k;
        logic hold_bad;
        logic acc;

        a_rst = 1'b1; a_fetch_en = 1'b0; a_fetch_addr = 3'd0; a_start = 1'b0; a_byte = 8'd0; a_bv = 1'b0;
        b_rst = 1'b1; b_fetch_en = 1'b0; b_fetch_addr = 2'd0; b_start = 1'b0; b_byte = 8'd0; b_bv = 1'b0;
        tick();
        tick();
        check("rst_instr", 64'(a_instr), 64'd0);
        check("rst_iv",    64'(a_iv),    64'd0);
        check("rst_busy",  64'(a_busy),  64'd0);
        check("rst_done",  64'(a_done),  64'd0);
        check("rst_ready", 64'(a_ready), 64'd0);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_wide_count", 64'(b_count), 64'd0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Default image and fetch-disable behaviour.
        fetch_a(3'd0, 16'h1C0A, "dflt_w0");
        fetch_a(3'd7, 16'hFC00, "dflt_w7");
        tick();
        check("nofetch_iv",   64'(a_iv),    64'd0);
        check("nofetch_hold", 64'(a_instr), 64'hFC00);

        // Bytes offered while idle must not be taken.
        a_bv   = 1'b1;
        a_byte = 8'hAA;
        check("idle_ready", 64'(a_ready), 64'd0);
        tick();
        check("idle_ready2", 64'(a_ready), 64'd0);
        check("idle_busy",   64'(a_busy),  64'd0);
        a_bv = 1'b0;

        // Reset after five accepted bytes: two whole words survive, partial is lost.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check("abort_busy", 64'(a_busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            a_byte = 8'(i);
            a_bv   = 1'b1;
            tick();
        end
        a_bv  = 1'b0;
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        check("abort_count", 64'(a_count), 64'd0);
        check("abort_busy0", 64'(a_busy),  64'd0);
        check("abort_ready", 64'(a_ready), 64'd0);
        fetch_a(3'd0, 16'h0001, "abort_w0");
        fetch_a(3'd1, 16'h0203, "abort_w1");
        fetch_a(3'd2, 16'hFC00, "abort_w2");

        // Full reload; start coincides with a fetch, and fetches continue through LOAD.
        a_start      = 1'b1;
        a_fetch_en   = 1'b1;
        a_fetch_addr = 3'd0;
        tick();
        a_start = 1'b0;
        check("start_fetch",   64'(a_instr), 64'h0001);
        check("start_fetch_v", 64'(a_iv),    64'd1);
        check("start_busy",    64'(a_busy),  64'd1);
        ready_cnt = 0;
        hold_bad  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_byte = 8'(i);
            a_bv   = 1'b1;
            if (a_ready) ready_cnt++;
            if (i == 15) check("done_early", 64'(a_done), 64'd0);
            tick();
            if (a_iv !== 1'b0 || a_instr !== 16'h0001) hold_bad = 1'b1;
        end
        a_bv = 1'b0;
        check("ready_cycles", 64'(ready_cnt), 64'd16);
        check("load_hold",    64'(hold_bad),  64'd0);
        check("done_pulse",   64'(a_done),    64'd1);
        check("done_busy",    64'(a_busy),    64'd0);
        check("done_ready",   64'(a_ready),   64'd0);
        check("done_count",   64'(a_count),   64'd8);
        a_fetch_addr = 3'd3;
        tick();
        check("reload_w3",    64'(a_instr), 64'h0607);
        check("reload_w3_v",  64'(a_iv),    64'd1);
        check("done_cleared", 64'(a_done),  64'd0);
        a_fetch_en = 1'b0;
        fetch_a(3'd7, 16'h0E0F, "reload_w7");

        // Gapped reload: valid alternates, same final image.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        k = 0;
        for (int c = 0; c < 64 && k < 16; c++) begin
            a_bv   = (c % 2 == 0);
            a_byte = 8'(k);
            acc    = a_bv && a_ready;
            tick();
            if (acc) k++;
        end
        a_bv = 1'b0;
        check("gap_accepted", 64'(k),       64'd16);
        check("gap_done",     64'(a_done),  64'd1);
        check("gap_count",    64'(a_count), 64'd8);
        fetch_a(3'd0, 16'h0001, "gap_w0");
        fetch_a(3'd3, 16'h0607, "gap_w3");
        fetch_a(3'd6, 16'h0C0D, "gap_w6");

        // Wide configuration: zero default image, then a 16-byte reload.
        fetch_b(2'd2, 32'h0000_0000, "wide_dflt");
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b_byte = 8'(i);
            b_bv   = 1'b1;
            if (i == 15) check("wide_done_early", 64'(b_done), 64'd0);
            tick();
        end
        b_bv = 1'b0;
        check("wide_done",  64'(b_done),  64'd1);
        check("wide_count", 64'(b_count), 64'd4);
        fetch_b(2'd1, 32'h0405_0607, "wide_w1");
        fetch_b(2'd3, 32'h0C0D_0E0F, "wide_w3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
